// File: rtl/ram_wr_queue.sv
// ram_wr_queue: write-side front end for the 32R1W replicated RAM.
// Two valid/ready producers are arbitrated round-robin into a DEPTH-entry
// FIFO. The FIFO drains at most one entry per clock into a registered write
// port (w_addr_1 / w_din_1 / w_enb_1), so every replicated block sees one
// clean write per cycle.
// Optional build macro WRQ_LEVEL_EN adds q_level (current occupancy) and
// q_hwm (sticky high-water mark since reset).
module ram_wr_queue #(
    parameter int BLOCKSIZE = 10,
    parameter int DEPTH     = 8,
    parameter int PTRW      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p0_valid,
    input  logic [BLOCKSIZE:0]   p0_addr,
    input  logic [31:0]          p0_data,
    output logic                 p0_ready,
    input  logic                 p1_valid,
    input  logic [BLOCKSIZE:0]   p1_addr,
    input  logic [31:0]          p1_data,
    output logic                 p1_ready,
    input  logic                 w_hold,
    output logic [BLOCKSIZE:0]   w_addr_1,
    output logic [31:0]          w_din_1,
    output logic                 w_enb_1,
    output logic                 q_empty,
    output logic                 q_full
`ifdef WRQ_LEVEL_EN
    ,
    output logic [PTRW:0]        q_level,
    output logic [PTRW:0]        q_hwm
`endif
);

    localparam int AW = BLOCKSIZE + 1;
    localparam int EW = AW + 32;
    localparam logic [PTRW:0]   FULL_CNT = (PTRW + 1)'(DEPTH);
    localparam logic [PTRW:0]   CNT_ONE  = (PTRW + 1)'(1);
    localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);

    // FIFO storage: {addr, data} per entry, no reset so it maps onto RAM
    logic [EW-1:0]   mem [0:DEPTH-1];

    logic [PTRW-1:0] wr_ptr_reg;
    logic [PTRW-1:0] rd_ptr_reg;
    logic [PTRW:0]   count_reg;
    logic [PTRW:0]   count_next;
    logic            last_grant_reg;

    logic            w_enb_reg;
    logic [AW-1:0]   w_addr_reg;
    logic [31:0]     w_din_reg;

    logic            empty;
    logic            full;
    logic [1:0]      req;
    logic [1:0]      grant;
    logic [1:0]      accept;
    logic [AW-1:0]   req_addr [2];
    logic [31:0]     req_data [2];
    logic            push;
    logic            push_sel;
    logic [EW-1:0]   push_entry;
    logic            pop;
    logic [EW-1:0]   head_entry;

    // Status flags come from the registered count only, so readiness never
    // depends on a pop happening in the same cycle.
    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_CNT);
    assign q_empty = empty;
    assign q_full  = full;

    // Producer bundle gathered into vectors so both arbitration slices are
    // built by the same generate loop.
    assign req         = {p1_valid, p0_valid};
    assign req_addr[0] = p0_addr;
    assign req_addr[1] = p1_addr;
    assign req_data[0] = p0_data;
    assign req_data[1] = p1_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_arb
            // A requester wins if it is alone, or if the other producer
            // was the one granted most recently.
            assign grant[gi]  = req[gi] & (~req[1 - gi] | (last_grant_reg != 1'(gi)));
            assign accept[gi] = grant[gi] & ~full;
        end
    endgenerate

    assign p0_ready   = accept[0];
    assign p1_ready   = accept[1];

    // At most one grant is ever active, so producer 1's grant selects the entry
    assign push       = |accept;
    assign push_sel   = accept[1];
    assign push_entry = {req_addr[push_sel], req_data[push_sel]};

    // Drain whenever something is queued and the RAM side is not holding us
    assign pop        = ~empty & ~w_hold;
    assign head_entry = mem[rd_ptr_reg];

    // Occupancy bookkeeping; a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Entry write into the queue storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    // Pointers, count and round-robin history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            last_grant_reg <= 1'b1;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg     <= wr_ptr_reg + PTR_ONE;
                last_grant_reg <= push_sel;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    // Registered RAM write port: one-cycle enable pulse per popped entry,
    // address/data hold their last value between writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_enb_reg  <= 1'b0;
            w_addr_reg <= '0;
            w_din_reg  <= '0;
        end else begin
            w_enb_reg <= pop;
            if (pop) begin
                w_addr_reg <= head_entry[EW-1:32];
                w_din_reg  <= head_entry[31:0];
            end
        end
    end

    assign w_enb_1  = w_enb_reg;
    assign w_addr_1 = w_addr_reg;
    assign w_din_1  = w_din_reg;

`ifdef WRQ_LEVEL_EN
    logic [PTRW:0] hwm_reg;

    // Sticky high-water mark; tracks count_next so it never lags q_level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hwm_reg <= '0;
        end else if (count_next > hwm_reg) begin
            hwm_reg <= count_next;
        end
    end

    assign q_level = count_reg;
    assign q_hwm   = hwm_reg;
`endif

endmodule

// File: tb/tb_ram_wr_queue.sv
// Directed bench for ram_wr_queue: reset, tie arbitration, single write,
// full/back-pressure, pointer wrap with w_hold toggling, mid-operation reset
// and (with WRQ_LEVEL_EN) the occupancy outputs.
module tb_ram_wr_queue;

    localparam int BLOCKSIZE = 10;
    localparam int DEPTH     = 8;
    localparam int PTRW      = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 p0_valid;
    logic [BLOCKSIZE:0]   p0_addr;
    logic [31:0]          p0_data;
    logic                 p0_ready;
    logic                 p1_valid;
    logic [BLOCKSIZE:0]   p1_addr;
    logic [31:0]          p1_data;
    logic                 p1_ready;
    logic                 w_hold;
    logic [BLOCKSIZE:0]   w_addr_1;
    logic [31:0]          w_din_1;
    logic                 w_enb_1;
    logic                 q_empty;
    logic                 q_full;
`ifdef WRQ_LEVEL_EN
    logic [PTRW:0]        q_level;
    logic [PTRW:0]        q_hwm;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [BLOCKSIZE:0] addr;
        logic [31:0]        data;
        int                 cyc;
    } wr_t;

    wr_t  out_q[$];
    logic pre_empty = 1'b1;
    logic pre_live  = 1'b0;

    ram_wr_queue #(
        .BLOCKSIZE (BLOCKSIZE),
        .DEPTH     (DEPTH),
        .PTRW      (PTRW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .p0_valid (p0_valid),
        .p0_addr  (p0_addr),
        .p0_data  (p0_data),
        .p0_ready (p0_ready),
        .p1_valid (p1_valid),
        .p1_addr  (p1_addr),
        .p1_data  (p1_data),
        .p1_ready (p1_ready),
        .w_hold   (w_hold),
        .w_addr_1 (w_addr_1),
        .w_din_1  (w_din_1),
        .w_enb_1  (w_enb_1),
        .q_empty  (q_empty),
        .q_full   (q_full)
`ifdef WRQ_LEVEL_EN
        ,
        .q_level  (q_level),
        .q_hwm    (q_hwm)
`endif
    );

    always #5 clk = ~clk;

    // Cycle counter plus push-side protocol assertions sampled at the edge
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        pre_empty <= q_empty;
        pre_live  <= rst;
        if (rst === 1'b1) begin
            checks++;
            if (q_full === 1'b1 && ((p0_valid && p0_ready) || (p1_valid && p1_ready))) begin
                errors++;
                $display("FAIL push_while_full: cyc=%0d p0_ready=%b p1_ready=%b required no push", cyc, p0_ready, p1_ready);
            end
            checks++;
            if (p0_ready === 1'b1 && p1_ready === 1'b1) begin
                errors++;
                $display("FAIL double_grant: cyc=%0d both ready, required at most one", cyc);
            end
        end
    end

    // Write-port monitor: records every RAM write and flags pops from an empty queue
    always @(negedge clk) begin
        if (w_enb_1 === 1'b1) begin
            out_q.push_back('{addr: w_addr_1, data: w_din_1, cyc: cyc});
            checks++;
            if (pre_live === 1'b1 && rst === 1'b1 && pre_empty === 1'b1) begin
                errors++;
                $display("FAIL pop_while_empty: cyc=%0d write addr=%h data=%h with queue empty", cyc, w_addr_1, w_din_1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (w_enb_1 !== 1'b0) begin errors++; $display("FAIL reset_w_enb: got %b required 0", w_enb_1); end
        checks++;
        if (w_addr_1 !== 11'h000) begin errors++; $display("FAIL reset_w_addr: got %h required 000", w_addr_1); end
        checks++;
        if (w_din_1 !== 32'h0) begin errors++; $display("FAIL reset_w_din: got %h required 00000000", w_din_1); end
        checks++;
        if (q_empty !== 1'b1) begin errors++; $display("FAIL reset_q_empty: got %b required 1", q_empty); end
        checks++;
        if (q_full !== 1'b0) begin errors++; $display("FAIL reset_q_full: got %b required 0", q_full); end
`ifdef WRQ_LEVEL_EN
        checks++;
        if (q_level !== 4'd0) begin errors++; $display("FAIL reset_q_level: got %0d required 0", q_level); end
        checks++;
        if (q_hwm !== 4'd0) begin errors++; $display("FAIL reset_q_hwm: got %0d required 0", q_hwm); end
`endif
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (w_enb_1 !== 1'b0 || q_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: w_enb_1=%b q_empty=%b required 0/1", w_enb_1, q_empty);
        end
    endtask

    // Both producers request together right after reset: p0 wins the first tie
    task automatic test_tie();
        logic [31:0] exp_data [4];
        logic [10:0] exp_addr [4];
        logic        exp_p0;
        exp_data = '{32'hA0, 32'hB0, 32'hA1, 32'hB1};
        exp_addr = '{11'h010, 11'h020, 11'h010, 11'h020};
        out_q.delete();
        @(negedge clk);
        p0_valid = 1'b1; p0_addr = 11'h010; p0_data = 32'hA0;
        p1_valid = 1'b1; p1_addr = 11'h020; p1_data = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_p0 = (i % 2 == 0);
            checks++;
            if (p0_ready !== exp_p0 || p1_ready !== !exp_p0) begin
                errors++;
                $display("FAIL tie_grant[%0d]: got p0_ready=%b p1_ready=%b required %b/%b", i, p0_ready, p1_ready, exp_p0, !exp_p0);
            end
            @(negedge clk);
            if (i == 0) p0_data = 32'hA1;
            if (i == 1) p1_data = 32'hB1;
            if (i == 2) p0_valid = 1'b0;
            if (i == 3) p1_valid = 1'b0;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (out_q.size() != 4) begin errors++; $display("FAIL tie_count: got %0d writes required 4", out_q.size()); end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i].addr !== exp_addr[i] || out_q[i].data !== exp_data[i]) begin
                errors++;
                $display("FAIL tie_order[%0d]: got %h/%h required %h/%h", i, out_q[i].addr, out_q[i].data, exp_addr[i], exp_data[i]);
            end
            checks++;
            if (out_q[i].cyc != out_q[0].cyc + i) begin
                errors++;
                $display("FAIL tie_b2b[%0d]: got cycle %0d required %0d", i, out_q[i].cyc, out_q[0].cyc + i);
            end
        end
    endtask

    task automatic test_single_write();
        out_q.delete();
        @(negedge clk);
        p0_valid = 1'b1; p0_addr = 11'h005; p0_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (p0_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b required 1", p0_ready); end
        @(negedge clk);
        p0_valid = 1'b0;
        checks++;
        if (q_empty !== 1'b0 || w_enb_1 !== 1'b0) begin
            errors++;
            $display("FAIL single_queued: q_empty=%b w_enb_1=%b required 0/0", q_empty, w_enb_1);
        end
        @(negedge clk);
        checks++;
        if (w_enb_1 !== 1'b1) begin errors++; $display("FAIL single_enb: got %b required 1", w_enb_1); end
        checks++;
        if (w_addr_1 !== 11'h005 || w_din_1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_data: got %h/%h required 005/deadbeef", w_addr_1, w_din_1);
        end
        checks++;
        if (q_empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b required 1", q_empty); end
        @(negedge clk);
        checks++;
        if (w_enb_1 !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b required 0", w_enb_1); end
        repeat (3) @(negedge clk);
        checks++;
        if (out_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d writes required 1", out_q.size()); end
    endtask

    // Fill to DEPTH under w_hold, confirm back-pressure, then drain
    task automatic test_full();
        out_q.delete();
        @(negedge clk);
        w_hold = 1'b1;
        for (int k = 0; k < 8; k++) begin
            p0_valid = 1'b1; p0_addr = 11'h100 + 11'(k); p0_data = 32'hC000_0000 + k;
            #1;
            checks++;
            if (p0_ready !== 1'b1) begin errors++; $display("FAIL full_accept[%0d]: got %b required 1", k, p0_ready); end
            @(negedge clk);
        end
        p0_addr = 11'h108; p0_data = 32'hC000_0008;
        #1;
        checks++;
        if (q_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b required 1", q_full); end
        checks++;
        if (p0_ready !== 1'b0) begin errors++; $display("FAIL full_refuse: got %b required 0", p0_ready); end
        repeat (2) begin
            @(negedge clk);
            #1;
            checks++;
            if (p0_ready !== 1'b0) begin errors++; $display("FAIL full_hold_refuse: got %b required 0", p0_ready); end
        end
        checks++;
        if (out_q.size() != 0) begin errors++; $display("FAIL full_hold_writes: got %0d writes required 0", out_q.size()); end
        @(negedge clk);
        w_hold = 1'b0;
        #1;
        checks++;
        if (p0_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass: got %b required 0", p0_ready); end
        @(negedge clk);
        checks++;
        if (w_enb_1 !== 1'b1) begin errors++; $display("FAIL full_first_pop: got %b required 1", w_enb_1); end
        #1;
        checks++;
        if (p0_ready !== 1'b1) begin errors++; $display("FAIL full_ready_rise: got %b required 1", p0_ready); end
        @(negedge clk);
        p0_addr = 11'h109; p0_data = 32'hC000_0009;
        #1;
        checks++;
        if (p0_ready !== 1'b1) begin errors++; $display("FAIL full_last_accept: got %b required 1", p0_ready); end
        @(negedge clk);
        p0_valid = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (out_q.size() != 10) begin errors++; $display("FAIL full_count: got %0d writes required 10", out_q.size()); end
        for (int i = 0; i < 10 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i].addr !== 11'h100 + 11'(i) || out_q[i].data !== 32'hC000_0000 + i) begin
                errors++;
                $display("FAIL full_order[%0d]: got %h/%h required %h/%h", i, out_q[i].addr, out_q[i].data, 11'h100 + 11'(i), 32'hC000_0000 + i);
            end
            checks++;
            if (out_q[i].cyc != out_q[0].cyc + i) begin
                errors++;
                $display("FAIL full_b2b[%0d]: got cycle %0d required %0d", i, out_q[i].cyc, out_q[0].cyc + i);
            end
        end
    endtask

    // 20 writes from p1 with w_hold toggling every 3 cycles; pointers wrap
    task automatic test_wrap();
        int   k;
        logic acc;
        k = 0;
        out_q.delete();
        @(negedge clk);
        for (int c = 0; c < 200 && k < 20; c++) begin
            w_hold   = ((c / 3) % 2) == 1;
            p1_valid = 1'b1; p1_addr = 11'h3F0 + 11'(k); p1_data = 32'h5000_0000 + k;
            #1;
            acc = p1_ready;
            @(negedge clk);
            if (acc) k++;
        end
        p1_valid = 1'b0;
        w_hold   = 1'b0;
        checks++;
        if (k != 20) begin errors++; $display("FAIL wrap_timeout: got %0d accepted required 20", k); end
        repeat (12) @(negedge clk);
        checks++;
        if (out_q.size() != 20) begin errors++; $display("FAIL wrap_count: got %0d writes required 20", out_q.size()); end
        for (int i = 0; i < 20 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i].addr !== 11'h3F0 + 11'(i) || out_q[i].data !== 32'h5000_0000 + i) begin
                errors++;
                $display("FAIL wrap_order[%0d]: got %h/%h required %h/%h", i, out_q[i].addr, out_q[i].data, 11'h3F0 + 11'(i), 32'h5000_0000 + i);
            end
        end
        checks++;
        if (q_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b required 1", q_empty); end
    endtask

    // Reset while draining: queue discarded, no stale writes, normal latency after
    task automatic test_reset_mid();
        out_q.delete();
        @(negedge clk);
        w_hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            p0_valid = 1'b1; p0_addr = 11'h0A0 + 11'(k); p0_data = 32'h7000_0000 + k;
            @(negedge clk);
        end
        p0_valid = 1'b0;
        w_hold   = 1'b0;
        @(negedge clk);
        checks++;
        if (w_enb_1 !== 1'b1 || w_din_1 !== 32'h7000_0000) begin
            errors++;
            $display("FAIL mid_pre_pop: got enb=%b data=%h required 1/70000000", w_enb_1, w_din_1);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (w_enb_1 !== 1'b0) begin errors++; $display("FAIL mid_enb_drop: got %b required 0", w_enb_1); end
        checks++;
        if (q_empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b required 1", q_empty); end
        checks++;
        if (w_addr_1 !== 11'h000) begin errors++; $display("FAIL mid_addr_clear: got %h required 000", w_addr_1); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        out_q.delete();
        repeat (6) @(negedge clk);
        checks++;
        if (out_q.size() != 0) begin errors++; $display("FAIL mid_stale: got %0d writes required 0", out_q.size()); end
        p0_valid = 1'b1; p0_addr = 11'h0C3; p0_data = 32'h1234_5678;
        #1;
        checks++;
        if (p0_ready !== 1'b1) begin errors++; $display("FAIL mid_next_ready: got %b required 1", p0_ready); end
        @(negedge clk);
        p0_valid = 1'b0;
        checks++;
        if (w_enb_1 !== 1'b0) begin errors++; $display("FAIL mid_next_early: got %b required 0", w_enb_1); end
        @(negedge clk);
        checks++;
        if (w_enb_1 !== 1'b1 || w_addr_1 !== 11'h0C3 || w_din_1 !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mid_next_write: got %b %h/%h required 1 0c3/12345678", w_enb_1, w_addr_1, w_din_1);
        end
        repeat (2) @(negedge clk);
    endtask

`ifdef WRQ_LEVEL_EN
    task automatic test_level();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (q_level !== 4'd0 || q_hwm !== 4'd0) begin
            errors++;
            $display("FAIL level_reset: got level=%0d hwm=%0d required 0/0", q_level, q_hwm);
        end
        @(negedge clk);
        w_hold = 1'b1;
        for (int k = 0; k < 6; k++) begin
            p0_valid = 1'b1; p0_addr = 11'h200 + 11'(k); p0_data = 32'h9000_0000 + k;
            @(negedge clk);
            checks++;
            if (q_level !== 4'(k + 1)) begin errors++; $display("FAIL level_up[%0d]: got %0d required %0d", k, q_level, k + 1); end
        end
        p0_valid = 1'b0;
        checks++;
        if (q_hwm !== 4'd6) begin errors++; $display("FAIL hwm_peak: got %0d required 6", q_hwm); end
        w_hold = 1'b0;
        for (int k = 5; k >= 0; k--) begin
            @(negedge clk);
            checks++;
            if (q_level !== 4'(k)) begin errors++; $display("FAIL level_down[%0d]: got %0d required %0d", k, q_level, k); end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (q_hwm !== 4'd6) begin errors++; $display("FAIL hwm_sticky: got %0d required 6", q_hwm); end
        rst = 1'b0;
        #1;
        checks++;
        if (q_hwm !== 4'd0) begin errors++; $display("FAIL hwm_clear: got %0d required 0", q_hwm); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        rst      = 1'b0;
        p0_valid = 1'b0; p0_addr = '0; p0_data = '0;
        p1_valid = 1'b0; p1_addr = '0; p1_data = '0;
        w_hold   = 1'b0;
        test_reset();
        test_tie();
        test_single_write();
        test_full();
        test_wrap();
        test_reset_mid();
`ifdef WRQ_LEVEL_EN
        test_level();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_wr_queue.md
Name: ram_wr_queue

Overview:
- Write-side front end for the 32R1W replicated RAM; sits directly upstream of its single write port (w_addr_1/w_din_1/w_enb_1).
- Accepts write requests from two producers over valid/ready, arbitrates round-robin, and buffers them in a DEPTH-entry FIFO.
- Drains at most one write per cycle into a registered write port, so all 32 replicated blocks see one clean write per clock.

Parameters:
- BLOCKSIZE, 10, address MSB index; address width is BLOCKSIZE+1 to match the RAM.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- PTRW, 3, log2(DEPTH).

Ports:
- clk  input  1  single clock, all flops on posedge.
- rst  input  1  asynchronous active-low reset.
- p0_valid  input  1  producer 0 request.
- p0_addr  input  BLOCKSIZE+1  producer 0 write address.
- p0_data  input  32  producer 0 write data.
- p0_ready  output  1  producer 0 accepted when valid&ready.
- p1_valid  input  1  producer 1 request.
- p1_addr  input  BLOCKSIZE+1  producer 1 write address.
- p1_data  input  32  producer 1 write data.
- p1_ready  output  1  producer 1 accepted when valid&ready.
- w_hold  input  1  pauses draining; FIFO keeps filling.
- w_addr_1  output  BLOCKSIZE+1  registered RAM write address.
- w_din_1  output  32  registered RAM write data.
- w_enb_1  output  1  registered RAM write enable, one-cycle pulse per write.
- q_empty  output  1  FIFO empty, combinational from count.
- q_full  output  1  FIFO full, combinational from count.

Behaviour:
- Reset (rst=0, async):
  - count=0, rd_ptr=0, wr_ptr=0.
  - w_enb_1=0, w_addr_1=0, w_din_1=0.
  - last_grant=1, so p0 wins the first tie.
  - q_empty=1, q_full=0.
- Reset asserted mid-operation discards all queued entries. No write pulse is emitted during or on the first edge after reset release.
- Ready:
  - While count<DEPTH, the ready port is 1 for a producer that is either the sole requester or the round-robin winner. Otherwise it is 0.
  - Ready is computed from registered count only. There is no same-cycle pop bypass, so a full FIFO refuses pushes even in a cycle where it pops.
- Arbitration:
  - At most one push per cycle.
  - If only one producer is valid, that producer is granted.
  - If both are valid, the producer other than last_grant is granted.
  - last_grant updates only on an actual push.
  - The loser sees ready=0 and must hold its request stable (valid, addr and data unchanged until accepted).
- Push: the granted {addr,data} is written at wr_ptr; wr_ptr increments modulo DEPTH and wraps naturally.
- Pop: occurs when count>0 and w_hold=0. On that edge:
  - w_enb_1<=1, w_addr_1<=head addr, w_din_1<=head data.
  - rd_ptr increments modulo DEPTH.
- When no pop occurs: w_enb_1<=0, and w_addr_1/w_din_1 hold their last values.
- Latency:
  - A request accepted at edge N into an empty queue appears with w_enb_1=1 after edge N+1.
  - Each further queued entry appears one cycle later, back to back.
- Simultaneous push and pop: count is unchanged. This is legal at any count between 1 and DEPTH-1.
- Ordering:
  - FIFO order is strict.
  - Two writes to the same address both reach the RAM in acceptance order, so the last accepted value wins.
- w_hold:
  - Takes effect on the same edge it is sampled high; the entry stays at the head.
  - w_enb_1 drops to 0 on that edge.
- Overflow or underflow is impossible by construction.
- Assertions: a push while full, or a pop while empty, is a design error and must be flagged by bench assertions.

Optional Feature:
- Macro: WRQ_LEVEL_EN.
- Defined:
  - Adds output q_level, width PTRW+1, equal to the registered count (reset 0).
  - Adds output q_hwm, width PTRW+1: a sticky high-water mark equal to the maximum count since reset, cleared only by rst.
- Undefined: both ports and their logic are absent; everything else is identical.

Test Plan:
- Single write: p0_valid=1, addr=0x005, data=0xDEADBEEF, for one cycle with queue empty -> p0_ready=1; exactly one w_enb_1 pulse two edges later with w_addr_1=0x005, w_din_1=0xDEADBEEF; q_empty returns to 1.
- Tie arbitration: both producers hold valid for 4 cycles with distinct data (p0: 0xA0..A1, p1: 0xB0..B1) -> accept order p0,p1,p0,p1; RAM writes in the same order on consecutive cycles.
- Full/back-pressure: w_hold=1, p0 streams 10 writes -> 8 accepted, q_full=1, p0_ready=0 for the rest. Release w_hold -> 8 consecutive w_enb_1 pulses in order. After the first pop, ready rises the next cycle and the remaining 2 are accepted with no loss.
- Wrap-around: 20 writes with w_hold toggling every 3 cycles -> output sequence matches input order across pointer wrap; count never exceeds 8.
- Reset mid-operation: 5 entries queued, assert rst for 1 cycle -> w_enb_1=0 immediately, q_empty=1, no stale writes after release; the next write appears with normal 2-edge latency.
- WRQ_LEVEL_EN build: queue 6 entries then drain -> q_level steps 1..6..0; q_hwm=6 and holds until rst.
